uart_io_port: RTL
=================

Name: uart_io_port

Overview:
- Memory-mapped I/O responder between the J1 I/O bus (initiator) and the byte-level UART core (buart handshake: rd/wr/tx_data/rx_data/busy/valid).
- Buffers received bytes in an RX FIFO and outgoing bytes in a TX FIFO, and exposes a status register, so CPU code never busy-waits on the UART bit timing.
- Replaces direct address decoding of the UART in the top level.

Parameters:
- BASE_ADDR, 16'h4000, base of the 3-register window.
- RX_DEPTH, 8, RX FIFO entries; power of 2, >= 2.
- TX_DEPTH, 8, TX FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock
- resetq  in  1  asynchronous active-low reset
- io_rd  in  1  CPU read strobe, one cycle
- io_wr  in  1  CPU write strobe, one cycle
- io_addr  in  16  CPU I/O address
- io_dout  in  16  write data from CPU
- io_din  out  16  read data to CPU
- uart_wr  out  1  one-cycle pulse: UART core loads uart_tx_data
- uart_tx_data  out  8  byte to transmit
- uart_busy  in  1  UART transmitter busy
- uart_rd  out  1  one-cycle pulse: acknowledge received byte
- uart_rx_data  in  8  received byte; valid while uart_valid=1
- uart_valid  in  1  UART holds an unread byte
- rx_avail  out  1  RX FIFO non-empty (LED/interrupt use)

Behaviour:
- Register map:
  - BASE+0 RX read: returns {8'h00, RX head} and pops. When empty, returns 16'h0000 and does not pop.
  - BASE+1 TX write: pushes io_dout[7:0]. When the TX FIFO is full, the write is dropped silently.
  - BASE+2 status read: {8'h00, rx_count[3:0], tx_empty, rx_overrun, tx_full, rx_avail}. rx_count saturates at 15. Reading clears rx_overrun on that edge.
  - BASE+2 write: io_dout[0]=1 flushes the RX FIFO; io_dout[1]=1 flushes the TX FIFO.
  - All other reads and writes in the window are ignored.
- Read timing:
  - io_din is combinational from io_addr and the FIFO heads. It is valid in the same cycle io_rd=1.
  - io_din is 16'h0000 when io_addr is outside the window.
  - Pop and clear-on-read take effect on the clk edge that ends the io_rd cycle.
- Reset (resetq=0, asynchronous): both FIFOs empty, pointers 0, rx_overrun=0, uart_wr=0, uart_rd=0, uart_tx_data=8'h00, rx_avail=0, both FSMs in IDLE. io_din then follows the empty state: status reads 16'h0008.
- RX FSM:
  - RX_IDLE: when uart_valid=1, capture uart_rx_data into the FIFO, pulse uart_rd for 1 cycle, go to RX_ACK.
    - If the FIFO is full and no CPU pop happens in the same cycle, the byte is discarded (still acked) and rx_overrun is set (sticky).
  - RX_ACK: wait until uart_valid=0, then go to RX_IDLE. This prevents double capture.
  - Capture-to-rx_avail latency: 1 cycle.
- TX FSM:
  - TX_IDLE: when the FIFO is non-empty and uart_busy=0, drive uart_tx_data=head, pulse uart_wr for 1 cycle, pop, go to TX_HOLD.
  - TX_HOLD: go to TX_BUSY when uart_busy=1, or after 2 cycles in TX_HOLD (guards against a missed busy).
  - TX_BUSY: when uart_busy=0, go to TX_IDLE.
  - Back-to-back bytes: uart_wr pulses are spaced by at least 1 idle cycle after busy falls.
- Simultaneous events:
  - CPU push and TX pop in the same cycle: both occur and the count is unchanged. A push to a full FIFO succeeds if a pop occurs in the same cycle.
  - CPU pop and RX capture in the same cycle: both occur, and a full FIFO does not overrun.
  - A flush in the same cycle as a capture or push: the flush wins and the FIFO ends empty.
  - A TX flush does not abort a byte already handed to the UART.
- Counters: pointers wrap modulo depth. Fullness uses a count of width log2(depth)+1, so there is no full/empty ambiguity.

Test Plan:
- Reset, then status read -> io_din=16'h0008; uart_wr=0, uart_rd=0, rx_avail=0.
- UART presents 8'h41 (valid held 3 cycles) -> exactly one uart_rd pulse; status 16'h0019; RX read returns 16'h0041; next status 16'h0008.
- Write 8'h55, 8'hAA to BASE+1 with uart_busy modelled at 10 cycles per byte -> two uart_wr pulses carrying 55 then AA, none while busy=1; tx_empty set after the second.
- Push 9 bytes with the UART held busy (TX_DEPTH=8) -> tx_full=1 after 8; the 9th is dropped; bytes 0..7 are emitted in order once busy releases.
- Deliver 9 RX bytes without CPU reads -> count=8, rx_overrun=1, data 0..7 intact; status read clears rx_overrun; an RX read on an empty FIFO returns 16'h0000.
- Assert resetq low mid-TX (TX_BUSY) and mid-RX (RX_ACK) -> all outputs return to reset values immediately; after release, no spurious uart_wr or uart_rd.

Source files
------------

// File: rtl/uart_io_port_if.sv
// rtl/uart_io_port_if.sv - CPU I/O bus and byte-UART handshake bundle for uart_io_port
interface uart_io_port_if;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;
    logic        uart_wr;
    logic [7:0]  uart_tx_data;
    logic        uart_busy;
    logic        uart_rd;
    logic [7:0]  uart_rx_data;
    logic        uart_valid;
    logic        rx_avail;

    modport slave (
        input  io_rd, io_wr, io_addr, io_dout, uart_busy, uart_rx_data, uart_valid,
        output io_din, uart_wr, uart_tx_data, uart_rd, rx_avail
    );

    modport master (
        output io_rd, io_wr, io_addr, io_dout, uart_busy, uart_rx_data, uart_valid,
        input  io_din, uart_wr, uart_tx_data, uart_rd, rx_avail
    );
endinterface

// File: rtl/uart_io_port.sv
// rtl/uart_io_port.sv - memory-mapped UART responder with RX/TX byte FIFOs and status register
module uart_io_port #(
    parameter logic [15:0] BASE_ADDR = 16'h4000,
    parameter int          RX_DEPTH  = 8,
    parameter int          TX_DEPTH  = 8
) (
    input  logic           clk,
    input  logic           resetq,
    uart_io_port_if.slave  bus
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW-1:0] RX_PTR_ONE  = 1;
    localparam logic [TX_AW-1:0] TX_PTR_ONE  = 1;
    localparam logic [RX_AW:0]   RX_CNT_ONE  = 1;
    localparam logic [TX_AW:0]   TX_CNT_ONE  = 1;
    localparam logic [RX_AW:0]   RX_CNT_FULL = (RX_AW+1)'(RX_DEPTH);
    localparam logic [TX_AW:0]   TX_CNT_FULL = (TX_AW+1)'(TX_DEPTH);

    typedef enum logic       {RX_IDLE, RX_ACK} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_HOLD, TX_BUSY} tx_state_t;

    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [RX_AW-1:0] r_rx_wp, r_rx_rp;
    logic [TX_AW-1:0] r_tx_wp, r_tx_rp;
    logic [RX_AW:0]   r_rx_cnt;
    logic [TX_AW:0]   r_tx_cnt;
    logic             r_rx_ovr;
    rx_state_t        r_rx_st;
    tx_state_t        r_tx_st;
    logic             r_hold_cnt;
    logic             r_uart_rd;
    logic             r_uart_wr;
    logic [7:0]       r_uart_tx_data;

    logic w_sel_rx, w_sel_tx, w_sel_st;
    logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic w_rx_pop, w_rx_cap, w_rx_push, w_rx_flush;
    logic w_tx_pop, w_tx_push, w_tx_flush, w_st_rd;
    logic [3:0] w_rx_cnt_sat;
    logic w_unused;

    assign w_sel_rx   = (bus.io_addr == BASE_ADDR);
    assign w_sel_tx   = (bus.io_addr == BASE_ADDR + 16'd1);
    assign w_sel_st   = (bus.io_addr == BASE_ADDR + 16'd2);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == RX_CNT_FULL);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == TX_CNT_FULL);

    // A CPU pop in the same cycle frees a slot, so a capture into a full FIFO still lands
    assign w_rx_pop   = bus.io_rd & w_sel_rx & ~w_rx_empty;
    assign w_rx_cap   = (r_rx_st == RX_IDLE) & bus.uart_valid;
    assign w_rx_push  = w_rx_cap & (~w_rx_full | w_rx_pop);
    assign w_rx_flush = bus.io_wr & w_sel_st & bus.io_dout[0];
    assign w_tx_pop   = (r_tx_st == TX_IDLE) & ~w_tx_empty & ~bus.uart_busy;
    assign w_tx_push  = bus.io_wr & w_sel_tx & (~w_tx_full | w_tx_pop);
    assign w_tx_flush = bus.io_wr & w_sel_st & bus.io_dout[1];
    assign w_st_rd    = bus.io_rd & w_sel_st;
    assign w_unused   = ^bus.io_dout[15:8];

    always_comb begin
        w_rx_cnt_sat = 4'(r_rx_cnt);
        if (32'(r_rx_cnt) > 15) w_rx_cnt_sat = 4'hF;
    end

    always_comb begin
        bus.io_din = 16'h0000;
        if (w_sel_rx && !w_rx_empty)
            bus.io_din = {8'h00, r_rx_mem[r_rx_rp]};
        else if (w_sel_st)
            bus.io_din = {8'h00, w_rx_cnt_sat, w_tx_empty, r_rx_ovr, w_tx_full, ~w_rx_empty};
    end

    assign bus.rx_avail     = ~w_rx_empty;
    assign bus.uart_rd      = r_uart_rd;
    assign bus.uart_wr      = r_uart_wr;
    assign bus.uart_tx_data = r_uart_tx_data;

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= bus.uart_rx_data;
        if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.io_dout[7:0];
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
            r_rx_ovr <= 1'b0;
        end else begin
            if (w_rx_flush) begin
                r_rx_wp  <= '0;
                r_rx_rp  <= '0;
                r_rx_cnt <= '0;
            end else begin
                if (w_rx_push) r_rx_wp <= r_rx_wp + RX_PTR_ONE;
                if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_PTR_ONE;
                if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + RX_CNT_ONE;
                else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - RX_CNT_ONE;
            end
            if (w_rx_cap && w_rx_full && !w_rx_pop) r_rx_ovr <= 1'b1;
            else if (w_st_rd)                       r_rx_ovr <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else if (w_tx_flush) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + TX_PTR_ONE;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_PTR_ONE;
            if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + TX_CNT_ONE;
            else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - TX_CNT_ONE;
        end
    end

    // RX_ACK holds off until the UART drops valid so one byte is never captured twice
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_rx_st   <= RX_IDLE;
            r_uart_rd <= 1'b0;
        end else begin
            r_uart_rd <= 1'b0;
            if (r_rx_st == RX_IDLE) begin
                if (bus.uart_valid) begin
                    r_uart_rd <= 1'b1;
                    r_rx_st   <= RX_ACK;
                end
            end else if (!bus.uart_valid) begin
                r_rx_st <= RX_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_tx_st        <= TX_IDLE;
            r_hold_cnt     <= 1'b0;
            r_uart_wr      <= 1'b0;
            r_uart_tx_data <= 8'h00;
        end else begin
            r_uart_wr <= 1'b0;
            case (r_tx_st)
                TX_IDLE: begin
                    if (w_tx_pop) begin
                        r_uart_tx_data <= r_tx_mem[r_tx_rp];
                        r_uart_wr      <= 1'b1;
                        r_hold_cnt     <= 1'b0;
                        r_tx_st        <= TX_HOLD;
                    end
                end
                // Leave HOLD after two cycles even if busy never shows, so a missed busy cannot stall TX
                TX_HOLD: begin
                    if (bus.uart_busy || r_hold_cnt) r_tx_st <= TX_BUSY;
                    else                             r_hold_cnt <= 1'b1;
                end
                TX_BUSY: begin
                    if (!bus.uart_busy) r_tx_st <= TX_IDLE;
                end
                default: r_tx_st <= TX_IDLE;
            endcase
        end
    end
endmodule
